gf_pow_seq: RTL and testbench
=============================

Name: gf_pow_seq

Overview:
- Sequential GF(2^m) exponentiation engine: computes result = a^e mod p(x) by right-to-left square-and-multiply.
- Sits downstream of the combinational carry-less multiply / polynomial-reduction stage and reuses the same operand conventions (polyn_grade, polyn_red_in).
- One shared carry-less multiplier plus reducer, one multiply per cycle.
- Also serves as the field inverter, via Fermat (optional feature).

Parameters:
- DATA_WIDTH, 32: operand/exponent width. Maximum supported field degree is DATA_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine idle, request accepted when in_valid & in_ready.
- polyn_grade  in  $clog2(DATA_WIDTH)+1  field degree m.
- polyn_red_in  in  DATA_WIDTH+1  irreducible polynomial including x^m term (e.g. 19 for m=4).
- a  in  DATA_WIDTH  base element; bits >= m ignored.
- e  in  DATA_WIDTH  exponent, unsigned integer.
- inv_req  in  1  inverse request (used only with GF_POW_INV_EN).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_WIDTH  a^e in GF(2^m); bits >= m are zero.
- err  out  1  qualified by out_valid; polyn_grade outside 2..DATA_WIDTH.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; result=0; err=0; internal registers cleared.
- States: IDLE, MUL, SQR, DONE.
- IDLE:
  - On in_valid & in_ready, register inputs. Operands are masked to m bits; exponent goes to an internal shift register.
  - Initialise acc=1, base=a_masked.
  - If m is out of range: go to DONE with err=1, result=0.
  - Else if e==0: go to DONE with result=1 (including a=0).
  - Else go to MUL.
- MUL (1 cycle):
  - If exp[0]=1, acc <= reduce(clmul(acc, base)); otherwise acc unchanged.
  - exp <= exp >> 1.
  - If the shifted exp==0, go to DONE; else go to SQR.
- SQR (1 cycle): base <= reduce(clmul(base, base)); go to MUL.
- Latency: with k = index of MSB of e, out_valid rises exactly 2k+1 cycles after the accepting edge. For e==0 or err, it rises after 1 cycle.
- DONE:
  - out_valid=1. result=acc and err are held stable until out_valid & out_ready.
  - On that handshake, return to IDLE. out_valid drops the next cycle and result stays latched.
- in_ready is 1 only in IDLE. No new request is accepted while busy or while a result is pending.
- Back-to-back: in_valid held high is accepted in the first IDLE cycle after the output handshake.
- Reduction (combinational, within the cycle):
  - Product is 2*DATA_WIDTH bits.
  - For bit i from 2m-2 down to m: if set, XOR polyn_red_in << (i-m).
  - Output is the low m bits.
- Inputs other than in_valid may change freely after acceptance.
- Reset asserted mid-operation aborts the operation; no partial result is presented.

Optional Feature:
- Macro: GF_POW_INV_EN.
- Defined:
  - When inv_req=1 at acceptance, the exponent is replaced by 2^m - 2 and e is ignored. Result is a^-1; 0 maps to 0. Latency follows the rule above with k=m-1.
  - inv_req=0 behaves normally.
- Undefined: inv_req is ignored and no override logic is synthesised.

Test Plan:
- m=4, poly=19, a=2, e=4 -> result=3, err=0, out_valid exactly 5 cycles after acceptance.
- m=4, poly=19, a=2, e=15 -> result=1 after 7 cycles; a=0, e=0 -> result=1 after 1 cycle.
- m=8, poly=285, a=2, e=8 -> result=29 after 7 cycles. Hold out_ready=0 for 10 cycles: result and out_valid stay stable and in_ready stays 0.
- polyn_grade=1 or polyn_grade=DATA_WIDTH+1 -> err=1, result=0, out_valid after 1 cycle.
- Assert rst for 1 cycle two cycles into an e=15 operation -> immediate in_ready=1, out_valid=0, result=0. Next request (m=4, a=3, e=1) -> result=3.
- GF_POW_INV_EN defined: m=4, poly=19, a=2, inv_req=1 -> result=9 after 7 cycles; a=0 -> 0. Macro undefined: same stimulus with e=4 -> result=3.
- Across all scenarios, a random self-check against a software square-and-multiply reference model, m in 2..16, using the standard irreducible polynomial table.

Source files
------------

// File: rtl/gf_pow_seq.sv
// Sequential GF(2^m) exponentiation, a^e mod p(x), right-to-left square-and-multiply
// on one shared carry-less multiplier + reducer. `GF_POW_INV_EN adds a^-1 via Fermat.
module gf_pow_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [$clog2(DATA_WIDTH):0] polyn_grade,
  input  logic [DATA_WIDTH:0]         polyn_red_in,
  input  logic [DATA_WIDTH-1:0]       a,
  input  logic [DATA_WIDTH-1:0]       e,
  input  logic                        inv_req,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       result,
  output logic                        err
);
  localparam int W  = DATA_WIDTH;
  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam logic [W-1:0]  ONE   = W'(1);
  localparam logic [GW-1:0] M_MIN = GW'(2);
  localparam logic [GW-1:0] M_MAX = GW'(W);

  typedef enum logic [1:0] {IDLE, MUL, SQR, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_acc, r_base, r_exp, r_result;
  logic [GW-1:0]   r_m;
  logic [W:0]      r_poly;
  logic            r_err_p, r_err, r_in_ready, r_out_valid;

  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_op_a, w_mul, w_mask, w_mask_in, w_e_eff, w_acc_next;
  logic            w_range_ok;

  function automatic logic [W-1:0] mask_of(input logic [GW-1:0] m);
    logic [W-1:0] mk;
    mk = '0;
    for (int i = 0; i < W; i++) mk[i] = (i < int'(m));
    return mk;
  endfunction

  assign w_mask     = mask_of(r_m);
  assign w_mask_in  = mask_of(polyn_grade);
  assign w_range_ok = (polyn_grade >= M_MIN) && (polyn_grade <= M_MAX);

`ifdef GF_POW_INV_EN
  // Fermat: a^(2^m - 2) == a^-1, and mask - 1 is exactly 2^m - 2.
  assign w_e_eff = inv_req ? (w_mask_in - ONE) : e;
`else
  logic w_unused_inv;
  assign w_unused_inv = inv_req;
  assign w_e_eff      = e;
`endif

  // One multiplier serves both steps: acc*base in MUL, base*base in SQR.
  always_comb begin
    w_op_a = (r_state == SQR) ? r_base : r_acc;
    w_prod = '0;
    for (int j = 0; j < W; j++)
      if (r_base[j]) w_prod = w_prod ^ ({{W{1'b0}}, w_op_a} << j);
    for (int i = 2*W-2; i >= 1; i--)
      if (i >= int'(r_m) && i <= 2*int'(r_m) - 2 && w_prod[i])
        w_prod = w_prod ^ ({{(W-1){1'b0}}, r_poly} << (i - int'(r_m)));
    w_mul = w_prod[W-1:0] & w_mask;
  end

  assign w_acc_next = r_exp[0] ? w_mul : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_base      <= '0;
      r_exp       <= '0;
      r_m         <= '0;
      r_poly      <= '0;
      r_err_p     <= 1'b0;
      r_err       <= 1'b0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid && r_in_ready) begin
          r_in_ready <= 1'b0;
          r_m        <= polyn_grade;
          r_poly     <= polyn_red_in;
          r_base     <= a & w_mask_in;
          r_state    <= MUL;
          // e==0 and bad m pass through one idle MUL (exp=0) to give the 1-cycle latency.
          if (!w_range_ok) begin
            r_acc   <= '0;
            r_exp   <= '0;
            r_err_p <= 1'b1;
          end else begin
            r_acc   <= ONE;
            r_exp   <= w_e_eff;
            r_err_p <= 1'b0;
          end
        end
        MUL: begin
          r_acc <= w_acc_next;
          r_exp <= r_exp >> 1;
          if (r_exp[W-1:1] == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_next;
            r_err       <= r_err_p;
          end else begin
            r_state <= SQR;
          end
        end
        SQR: begin
          r_base  <= w_mul;
          r_state <= MUL;
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign err       = r_err;
endmodule

// File: tb/tb_gf_pow_seq.sv
// Bench for gf_pow_seq: directed vectors plus random checks against a
// left-to-right shift-and-add GF(2^m) model. Adapts to `GF_POW_INV_EN.
module tb_gf_pow_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, inv_req, out_ready;
  logic [5:0]  polyn_grade;
  logic [32:0] polyn_red_in;
  logic [31:0] a, e;
  logic        in_ready, out_valid, err;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  gf_pow_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .polyn_grade(polyn_grade), .polyn_red_in(polyn_red_in), .a(a), .e(e),
    .inv_req(inv_req), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint unsigned ref_poly(input int m);
    case (m)
      2: return 7;      3: return 11;     4: return 19;     5: return 37;
      6: return 67;     7: return 131;    8: return 285;    9: return 529;
      10: return 1033;  11: return 2053;  12: return 4179;  13: return 8219;
      14: return 17475; 15: return 32771; default: return 69643;
    endcase
  endfunction

  // x*y in GF(2^m): add x for each set bit of y, multiplying x by the generator each step.
  function automatic longint unsigned ref_mul(input longint unsigned x, input longint unsigned y,
                                              input int m, input longint unsigned p);
    longint unsigned r = 0;
    for (int i = 0; i < m; i++) begin
      if (((y >> i) & 1) != 0) r = r ^ x;
      x = x << 1;
      if (((x >> m) & 1) != 0) x = x ^ p;
    end
    return r;
  endfunction

  function automatic longint unsigned ref_pow(input longint unsigned x, input logic [31:0] ev,
                                              input int m, input longint unsigned p);
    longint unsigned r = 1;
    x = x & ((64'd1 << m) - 1);
    for (int i = 31; i >= 0; i--) begin
      r = ref_mul(r, r, m, p);
      if (ev[i]) r = ref_mul(r, x, m, p);
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [31:0] ev);
    int k = 0;
    for (int i = 0; i < 32; i++) if (ev[i]) k = i;
    return 2 * k + 1;
  endfunction

  // Issue one request, wait for the result, then complete the output handshake.
  task automatic run_op(input int m, input logic [32:0] p, input logic [31:0] av,
                        input logic [31:0] ev, input logic inv,
                        output logic [31:0] res, output logic er, output int lat);
    int g = 0;
    @(negedge clk);
    polyn_grade = 6'(m); polyn_red_in = p; a = av; e = ev; inv_req = inv; in_valid = 1'b1;
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; e = $urandom; polyn_grade = 6'($urandom); inv_req = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    res = result; er = err;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; inv_req = 1'b0; out_ready = 1'b0;
    polyn_grade = '0; polyn_red_in = '0; a = '0; e = '0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%0d err=%b, want 1 0 0 0",
               in_ready, out_valid, result, err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_plan();
    int          tm[4] = '{4, 4, 4, 8};
    int          ta[4] = '{2, 2, 0, 2};
    int          te[4] = '{4, 15, 0, 8};
    int          tr[4] = '{3, 1, 1, 29};
    int          tl[4] = '{5, 7, 1, 7};
    logic [31:0] res;
    logic        er;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(tm[i], 33'(ref_poly(tm[i])), 32'(ta[i]), 32'(te[i]), 1'b0, res, er, lat);
      checks++;
      if (res !== 32'(tr[i]) || er !== 1'b0 || lat != tl[i]) begin
        failures++;
        $display("FAIL plan[%0d]: result=%0d err=%b lat=%0d, want %0d 0 %0d",
                 i, res, er, lat, tr[i], tl[i]);
      end
    end
  endtask

  task automatic test_hold();
    int g = 0;
    @(negedge clk);
    polyn_grade = 6'd8; polyn_red_in = 33'd285; a = 32'd2; e = 32'd8; inv_req = 1'b0;
    in_valid = 1'b1;
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    a = 32'd5; e = 32'd1;
    g = 0;
    while (!out_valid && g < 300) begin @(posedge clk); #1; g++; end
    checks++;
    if (g != 7) begin
      failures++;
      $display("FAIL hold_latency: lat=%0d want 7", g);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== 32'd29 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: result=%0d out_valid=%b in_ready=%b, want 29 1 0",
                 c, result, out_valid, in_ready);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd29) begin
      failures++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b result=%0d, want 0 1 29",
               out_valid, in_ready, result);
    end
  endtask

  task automatic test_err();
    int          gr[2] = '{1, 33};
    logic [31:0] res;
    logic        er;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      run_op(gr[i], 33'd19, 32'd7, 32'd9, 1'b0, res, er, lat);
      checks++;
      if (res !== 32'd0 || er !== 1'b1 || lat != 1) begin
        failures++;
        $display("FAIL err_grade%0d: result=%0d err=%b lat=%0d, want 0 1 1", gr[i], res, er, lat);
      end
    end
  endtask

  task automatic test_midreset();
    logic [31:0] res;
    logic        er;
    int          lat;
    int          g = 0;
    @(negedge clk);
    polyn_grade = 6'd4; polyn_red_in = 33'd19; a = 32'd2; e = 32'd15; inv_req = 1'b0;
    in_valid = 1'b1;
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL midreset: in_ready=%b out_valid=%b result=%0d, want 1 0 0",
               in_ready, out_valid, result);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_abort: out_valid=%b want 0", out_valid);
    end
    run_op(4, 33'd19, 32'd3, 32'd1, 1'b0, res, er, lat);
    checks++;
    if (res !== 32'd3 || er !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL midreset_next: result=%0d err=%b lat=%0d, want 3 0 1", res, er, lat);
    end
  endtask

  task automatic test_inv();
    logic [31:0] res;
    logic        er;
    int          lat;
`ifdef GF_POW_INV_EN
    run_op(4, 33'd19, 32'd2, 32'd4, 1'b1, res, er, lat);
    checks++;
    if (res !== 32'd9 || lat != 7) begin
      failures++;
      $display("FAIL inv_a2: result=%0d lat=%0d, want 9 7", res, lat);
    end
    run_op(4, 33'd19, 32'd0, 32'd4, 1'b1, res, er, lat);
    checks++;
    if (res !== 32'd0 || lat != 7) begin
      failures++;
      $display("FAIL inv_a0: result=%0d lat=%0d, want 0 7", res, lat);
    end
`else
    run_op(4, 33'd19, 32'd2, 32'd4, 1'b1, res, er, lat);
    checks++;
    if (res !== 32'd3 || lat != 5) begin
      failures++;
      $display("FAIL inv_ignored: result=%0d lat=%0d, want 3 5", res, lat);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] a2, e2, exp1, exp2;
    int          g = 0;
    a2 = $urandom; e2 = 32'($urandom_range(1, 255));
    exp1 = 32'(ref_pow(64'd3, 32'd2, 4, 19));
    exp2 = 32'(ref_pow(64'(a2), e2, 8, 285));
    @(negedge clk);
    polyn_grade = 6'd4; polyn_red_in = 33'd19; a = 32'd3; e = 32'd2; inv_req = 1'b0;
    in_valid = 1'b1;
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    polyn_grade = 6'd8; polyn_red_in = 33'd285; a = a2; e = e2;
    g = 0;
    while (!out_valid && g < 300) begin @(posedge clk); #1; g++; end
    checks++;
    if (result !== exp1 || g != 3) begin
      failures++;
      $display("FAIL b2b_first: result=%0d lat=%0d, want %0d 3", result, g, exp1);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: in_ready=%b want 0", in_ready);
    end
    g = 0;
    while (!out_valid && g < 300) begin @(posedge clk); #1; g++; end
    checks++;
    if (result !== exp2 || err !== 1'b0 || g != ref_lat(e2)) begin
      failures++;
      $display("FAIL b2b_second: result=%0d err=%b lat=%0d, want %0d 0 %0d",
               result, err, g, exp2, ref_lat(e2));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] res, av, ev, eeff, expv;
    logic        er, inv;
    int          lat, m;
    for (int n = 0; n < 40; n++) begin
      m   = $urandom_range(2, 16);
      av  = $urandom;
      ev  = $urandom >> $urandom_range(0, 31);
      inv = ($urandom_range(0, 3) == 0);
      eeff = ev;
`ifdef GF_POW_INV_EN
      if (inv) eeff = 32'((64'd1 << m) - 2);
`endif
      expv = 32'(ref_pow(64'(av), eeff, m, ref_poly(m)));
      run_op(m, 33'(ref_poly(m)), av, ev, inv, res, er, lat);
      checks++;
      if (res !== expv || er !== 1'b0 || lat != ref_lat(eeff)) begin
        failures++;
        $display("FAIL random[%0d] m=%0d a=%h e=%h inv=%b: result=%h err=%b lat=%0d, want %h 0 %0d",
                 n, m, av, ev, inv, res, er, lat, expv, ref_lat(eeff));
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_hold();
    test_midreset();
    test_err();
    test_inv();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
